bcd_down_timer: RTL

Two-digit BCD down-counting timer: the opposite direction to the team's BCD up-counter. Software or an upstream controller loads a 00–99 BCD preset. The block then decrements it once every PRESCALE clocks and emits a one-cycle DONE pulse on reaching 00, optionally reloading the preset. It sits beside the up-counter in the display/timing path and drives the same 8-bit packed-BCD Q format.

---
 rtl/bcd_down_timer.sv | 103 ++++++++++
 1 files changed

// File: rtl/bcd_down_timer.sv
// Two-digit packed-BCD down-counting timer with prescaler, DONE pulse on
// reaching 00, optional auto-reload and a sticky invalid-preset flag.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  IDLE     | loaded or paused; waits for START with a non-zero count
//  RUNNING  | prescaler advancing, Q steps once every PRESCALE clocks
//  EXPIRED  | count reached 00 and stopped; only LOAD or reset leave it
module bcd_down_timer #(
   parameter int PRESCALE    = 4,
   parameter bit AUTO_RELOAD = 1'b0
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       LOAD,
   input  logic [7:0] DIN,
   input  logic       START,
   input  logic       STOP,
   output logic [7:0] Q,
   output logic       RUN,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;

   localparam logic [7:0] PC_LAST = 8'(PRESCALE - 1);

   state_t     state;
   logic [7:0] pr;
   logic [7:0] pc;
   logic       din_ok;
   logic [7:0] q_dec;

   assign din_ok = (DIN[7:4] <= 4'd9) && (DIN[3:0] <= 4'd9);

   // Digit-wise decrement: borrowing from tens reloads units with 9.
   always_comb begin
      q_dec = Q;
      if (Q[3:0] != 4'd0) begin
         q_dec[3:0] = Q[3:0] - 4'd1;
      end else begin
         q_dec[3:0] = 4'd9;
         q_dec[7:4] = Q[7:4] - 4'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
         Q     <= 8'h00;
         pr    <= 8'h00;
         pc    <= 8'h00;
         RUN   <= 1'b0;
         DONE  <= 1'b0;
         ERR   <= 1'b0;
      end else begin
         DONE <= 1'b0;
         if (LOAD) begin
            if (din_ok) begin
               Q     <= DIN;
               pr    <= DIN;
               pc    <= 8'h00;
               ERR   <= 1'b0;
               state <= IDLE;
               RUN   <= 1'b0;
            end else begin
               ERR <= 1'b1;
            end
         end else if (STOP) begin
            if (state == RUNNING) begin
               state <= IDLE;
               RUN   <= 1'b0;
            end
         end else if (state == IDLE) begin
            // pc is kept so a paused count finishes its partial period
            if (START && (Q != 8'h00)) begin
               state <= RUNNING;
               RUN   <= 1'b1;
            end
         end else if (state == RUNNING) begin
            if (pc == PC_LAST) begin
               pc <= 8'h00;
               if (Q == 8'h01) begin
                  DONE <= 1'b1;
                  if (AUTO_RELOAD && (pr != 8'h00)) begin
                     Q <= pr;
                  end else begin
                     Q     <= 8'h00;
                     state <= EXPIRED;
                     RUN   <= 1'b0;
                  end
               end else begin
                  Q <= q_dec;
               end
            end else begin
               pc <= pc + 8'd1;
            end
         end
      end
   end

endmodule
